// File: rtl/sumador_serie_ctrl.sv
// Multi-nibble unsigned adder sequencer that time-shares one external 4-bit adder.
// Two adder passes per nibble (A+B, then partial+carry) build the missing carry chain.
module sumador_serie_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inicio_i,
    input  logic [4*NIBBLES-1:0] operandoA_i,
    input  logic [4*NIBBLES-1:0] operandoB_i,
    output logic                 ocupado_o,
    output logic                 listo_o,
    output logic [4*NIBBLES:0]   resultado_o,
    output logic [3:0]           sumandoA_o,
    output logic [3:0]           sumandoB_o,
    input  logic [4:0]           suma_i
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        SUMA_AB = 2'd1,
        SUMA_C  = 2'd2,
        FIN     = 2'd3
    } estado_t;

    estado_t          state_q, state_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic [W-1:0]     acum_q, acum_d;
    logic [4:0]       parcial_q, parcial_d;
    logic             acarreo_q, acarreo_d;
    logic [IDX_W-1:0] indice_q, indice_d;
    logic             ocupado_q, ocupado_d;
    logic             listo_q, listo_d;
    logic [W:0]       resultado_q, resultado_d;
    logic [3:0]       sumando_a_s, sumando_b_s;

    function automatic logic [3:0] nibble_sel(input logic [W-1:0] v, input logic [IDX_W-1:0] idx);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                r = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] nibble_put(input logic [W-1:0] v, input logic [IDX_W-1:0] idx,
                                                input logic [3:0] n);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                r[4*i +: 4] = n;
            end
        end
        return r;
    endfunction

    // Next-state, datapath updates and adder operand selection.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        acum_d      = acum_q;
        parcial_d   = parcial_q;
        acarreo_d   = acarreo_q;
        indice_d    = indice_q;
        resultado_d = resultado_q;
        listo_d     = 1'b0;
        ocupado_d   = (state_q != REPOSO);
        sumando_a_s = 4'h0;
        sumando_b_s = 4'h0;

        case (state_q)
            REPOSO: begin
                // ocupado_q still high during the listo cycle keeps a start there from sneaking in
                if (inicio_i && !ocupado_q) begin
                    op_a_d    = operandoA_i;
                    op_b_d    = operandoB_i;
                    indice_d  = '0;
                    acarreo_d = 1'b0;
                    state_d   = SUMA_AB;
                end else begin
                    state_d = REPOSO;
                end
            end
            SUMA_AB: begin
                sumando_a_s = nibble_sel(op_a_q, indice_q);
                sumando_b_s = nibble_sel(op_b_q, indice_q);
                parcial_d   = suma_i;
                state_d     = SUMA_C;
            end
            SUMA_C: begin
                sumando_a_s = parcial_q[3:0];
                sumando_b_s = {3'b000, acarreo_q};
                acum_d      = nibble_put(acum_q, indice_q, suma_i[3:0]);
                acarreo_d   = parcial_q[4] | suma_i[4];
                if (indice_q == IDX_LAST) begin
                    state_d = FIN;
                end else begin
                    indice_d = indice_q + IDX_W'(1);
                    state_d  = SUMA_AB;
                end
            end
            FIN: begin
                resultado_d = {acarreo_q, acum_q};
                listo_d     = 1'b1;
                state_d     = REPOSO;
            end
            default: begin
                state_d = REPOSO;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= REPOSO;
            op_a_q      <= '0;
            op_b_q      <= '0;
            acum_q      <= '0;
            parcial_q   <= 5'd0;
            acarreo_q   <= 1'b0;
            indice_q    <= '0;
            ocupado_q   <= 1'b0;
            listo_q     <= 1'b0;
            resultado_q <= '0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            acum_q      <= acum_d;
            parcial_q   <= parcial_d;
            acarreo_q   <= acarreo_d;
            indice_q    <= indice_d;
            ocupado_q   <= ocupado_d;
            listo_q     <= listo_d;
            resultado_q <= resultado_d;
        end
    end

    assign ocupado_o   = ocupado_q;
    assign listo_o     = listo_q;
    assign resultado_o = resultado_q;
    assign sumandoA_o  = sumando_a_s;
    assign sumandoB_o  = sumando_b_s;

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Self-checking bench for sumador_serie_ctrl: three instances (4, 1 and 2 nibbles),
// each driving an ideal 4-bit adder model, checked against plain integer arithmetic.
module tb_sumador_serie_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic        ini4, ocu4, lis4;
    logic [15:0] a4, b4;
    logic [16:0] res4;
    logic [3:0]  sa4, sb4;
    logic [4:0]  suma4;
    assign suma4 = {1'b0, sa4} + {1'b0, sb4};

    logic        ini1, ocu1, lis1;
    logic [3:0]  a1, b1;
    logic [4:0]  res1;
    logic [3:0]  sa1, sb1;
    logic [4:0]  suma1;
    assign suma1 = {1'b0, sa1} + {1'b0, sb1};

    logic        ini2, ocu2, lis2;
    logic [7:0]  a2, b2;
    logic [8:0]  res2;
    logic [3:0]  sa2, sb2;
    logic [4:0]  suma2;
    assign suma2 = {1'b0, sa2} + {1'b0, sb2};

    sumador_serie_ctrl #(.NIBBLES(4)) u4 (
        .clk_i(clk), .rst_i(rst), .inicio_i(ini4), .operandoA_i(a4), .operandoB_i(b4),
        .ocupado_o(ocu4), .listo_o(lis4), .resultado_o(res4),
        .sumandoA_o(sa4), .sumandoB_o(sb4), .suma_i(suma4));

    sumador_serie_ctrl #(.NIBBLES(1)) u1 (
        .clk_i(clk), .rst_i(rst), .inicio_i(ini1), .operandoA_i(a1), .operandoB_i(b1),
        .ocupado_o(ocu1), .listo_o(lis1), .resultado_o(res1),
        .sumandoA_o(sa1), .sumandoB_o(sb1), .suma_i(suma1));

    sumador_serie_ctrl #(.NIBBLES(2)) u2 (
        .clk_i(clk), .rst_i(rst), .inicio_i(ini2), .operandoA_i(a2), .operandoB_i(b2),
        .ocupado_o(ocu2), .listo_o(lis2), .resultado_o(res2),
        .sumandoA_o(sa2), .sumandoB_o(sb2), .suma_i(suma2));

    // Advance one cycle on the 4-nibble instance; optionally inject a start request in cycle c == inj.
    task automatic tick4(input int c, input int inj, input logic [15:0] ia, input logic [15:0] ib);
        @(posedge clk);
        #1;
        if (c == inj) begin
            a4   = ia;
            b4   = ib;
            ini4 = 1'b1;
        end else begin
            ini4 = 1'b0;
        end
    endtask

    // One full 4-nibble sum, checking per-cycle adder operands, ocupado, latency and result.
    task automatic op4(input logic [15:0] a, input logic [15:0] b, input int inj,
                       input logic [15:0] ia, input logic [15:0] ib, input string nm);
        logic [16:0] exp_res;
        logic [4:0]  p;
        logic        cy;
        int          lat;
        exp_res = {1'b0, a} + {1'b0, b};
        cy      = 1'b0;
        p       = 5'd0;
        lat     = -1;
        a4   = a;
        b4   = b;
        ini4 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick4(c, inj, ia, ib);
            checks++;
            if (ocu4 !== ((c == 0) ? 1'b0 : 1'b1) || lis4 !== 1'b0) begin
                errors++;
                $display("FAIL %s ocu_lis_c%0d got ocupado=%b listo=%b exp ocupado=%b listo=0",
                         nm, c, ocu4, lis4, (c != 0));
            end
            if (c % 2 == 0) begin
                p = {1'b0, a[4*(c/2) +: 4]} + {1'b0, b[4*(c/2) +: 4]};
                checks++;
                if (sa4 !== a[4*(c/2) +: 4] || sb4 !== b[4*(c/2) +: 4]) begin
                    errors++;
                    $display("FAIL %s pass_ab_c%0d got %h/%h exp %h/%h", nm, c, sa4, sb4,
                             a[4*(c/2) +: 4], b[4*(c/2) +: 4]);
                end
            end else begin
                checks++;
                if (sa4 !== p[3:0] || sb4 !== {3'b000, cy}) begin
                    errors++;
                    $display("FAIL %s pass_c_c%0d got %h/%h exp %h/%h", nm, c, sa4, sb4, p[3:0], {3'b000, cy});
                end
                checks++;
                if (p[4] && suma4[4]) begin
                    errors++;
                    $display("FAIL %s double_carry_c%0d got parcial4=1 suma4=1 exp not both", nm, c);
                end
                cy = p[4] | (({1'b0, p[3:0]} + {4'b0000, cy}) > 5'd15);
            end
        end
        for (int c = 8; c < 20 && lat < 0; c++) begin
            tick4(c, inj, ia, ib);
            if (lis4 === 1'b1) lat = c;
        end
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL %s latency got %0d exp 9", nm, lat);
        end
        checks++;
        if (res4 !== exp_res || ocu4 !== 1'b1) begin
            errors++;
            $display("FAIL %s result got %h ocupado=%b exp %h ocupado=1", nm, res4, ocu4, exp_res);
        end
        tick4(lat + 1, inj, ia, ib);
        checks++;
        if (lis4 !== 1'b0 || ocu4 !== 1'b0 || res4 !== exp_res) begin
            errors++;
            $display("FAIL %s after_listo got listo=%b ocupado=%b res=%h exp 0 0 %h", nm, lis4, ocu4, res4, exp_res);
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        ini4 = 1'b0; a4 = 16'h0000; b4 = 16'h0000;
        ini1 = 1'b0; a1 = 4'h0;     b1 = 4'h0;
        ini2 = 1'b0; a2 = 8'h00;    b2 = 8'h00;
        #12;
        checks++;
        if (ocu4 !== 1'b0 || lis4 !== 1'b0 || res4 !== 17'h00000 || sa4 !== 4'h0 || sb4 !== 4'h0) begin
            errors++;
            $display("FAIL reset_n4 got ocu=%b lis=%b res=%h sa=%h sb=%h exp all 0", ocu4, lis4, res4, sa4, sb4);
        end
        checks++;
        if (ocu1 !== 1'b0 || lis1 !== 1'b0 || res1 !== 5'h00 || ocu2 !== 1'b0 || lis2 !== 1'b0 || res2 !== 9'h000) begin
            errors++;
            $display("FAIL reset_small got ocu1=%b lis1=%b res1=%h ocu2=%b lis2=%b res2=%h exp all 0",
                     ocu1, lis1, res1, ocu2, lis2, res2);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        op4(16'h1234, 16'h4321, -1, 16'h0, 16'h0, "d_1234_4321");
        op4(16'hFFFF, 16'h0001, -1, 16'h0, 16'h0, "d_ffff_0001");
        op4(16'hFFFF, 16'hFFFF, -1, 16'h0, 16'h0, "d_ffff_ffff");
        op4(16'h0000, 16'h0000, -1, 16'h0, 16'h0, "d_zero");
    endtask

    task automatic test_back_to_back;
        op4(16'h00FF, 16'h0001, 3, 16'h1111, 16'h1111, "ignore_busy");
        op4(16'h1111, 16'h1111, -1, 16'h0, 16'h0, "back_to_back");
    endtask

    task automatic test_abort;
        int seen;
        seen = 0;
        a4   = 16'h1234;
        b4   = 16'h1111;
        ini4 = 1'b1;
        for (int c = 0; c <= 4; c++) tick4(c, -1, 16'h0, 16'h0);
        rst = 1'b1;
        #1;
        checks++;
        if (ocu4 !== 1'b0 || lis4 !== 1'b0 || res4 !== 17'h00000) begin
            errors++;
            $display("FAIL abort_reset got ocu=%b lis=%b res=%h exp 0 0 0", ocu4, lis4, res4);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick4(c, -1, 16'h0, 16'h0);
            if (lis4 !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_listo got %0d listo cycles exp 0", seen);
        end
        op4(16'h8000, 16'h8000, -1, 16'h0, 16'h0, "abort_restart");
    endtask

    // Sum on the 1- or 2-nibble instance, checking latency 2n+1 and the result.
    task automatic test_small(input int n, input logic [7:0] a, input logic [7:0] b, input string nm);
        logic [8:0] exp_res;
        logic [8:0] got;
        int         lat;
        lat = -1;
        if (n == 1) begin
            exp_res = {4'b0000, ({1'b0, a[3:0]} + {1'b0, b[3:0]})};
            a1 = a[3:0]; b1 = b[3:0]; ini1 = 1'b1;
        end else begin
            exp_res = {1'b0, a} + {1'b0, b};
            a2 = a; b2 = b; ini2 = 1'b1;
        end
        @(posedge clk);
        #1;
        ini1 = 1'b0;
        ini2 = 1'b0;
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            if (((n == 1) ? lis1 : lis2) === 1'b1) lat = c;
        end
        checks++;
        if (lat != 2 * n + 1) begin
            errors++;
            $display("FAIL %s latency got %0d exp %0d", nm, lat, 2 * n + 1);
        end
        got = (n == 1) ? {4'b0000, res1} : res2;
        checks++;
        if (got !== exp_res) begin
            errors++;
            $display("FAIL %s result got %h exp %h", nm, got, exp_res);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        for (int k = 0; k < 24; k++) begin
            if (k % 4 == 3) begin
                op4(16'($urandom), 16'($urandom), $urandom_range(1, 7), 16'($urandom), 16'($urandom), "rand_inj");
            end else begin
                op4(16'($urandom), 16'($urandom), -1, 16'h0, 16'h0, "rand");
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        for (int k = 0; k < 8; k++) begin
            test_small(1, 8'($urandom), 8'($urandom), "rand_n1");
            test_small(2, 8'($urandom), 8'($urandom), "rand_n2");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_small(1, 8'h0F, 8'h01, "n1_f_1");
        test_small(2, 8'h9F, 8'h61, "n2_9f_61");
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sumador_serie_ctrl.md
Name: sumador_serie_ctrl

Overview:
- Multi-nibble unsigned adder controller that time-shares one external 4-bit unsigned adder (two 4-bit inputs, 5-bit sum, no carry-in).
- Adds two NIBBLES×4-bit operands one nibble per step, LSB nibble first.
- Each step spends two adder passes: A+B, then the partial sum plus the stored carry. This builds the carry chain that the bare adder lacks.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (≥1); operand width W=4*NIBBLES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
inicio  input  1  start request, sampled only in REPOSO
operandoA  input  W  first operand, captured on accepted start
operandoB  input  W  second operand, captured on accepted start
ocupado  output  1  high while a sum is in progress (state != REPOSO)
listo  output  1  one-cycle completion pulse
resultado  output  W+1  final sum incl. carry-out at bit W; held until next completion
sumandoA  output  4  to adder input A (combinational from state)
sumandoB  output  4  to adder input B (combinational from state)
suma  input  5  from adder output, zero-extended sum, combinational

Behaviour:
- Reset (async, rst=1): state=REPOSO, ocupado=0, listo=0, resultado=0, indice=0, acarreo=0, parcial=0, latched operands=0. An operation in progress is abandoned; no listo pulse is issued.
- States: REPOSO, SUMA_AB, SUMA_C, FIN.
- REPOSO:
  - sumandoA=sumandoB=0.
  - If inicio=1: latch operandoA/B into opA/opB, indice<=0, acarreo<=0, go SUMA_AB.
  - Else stay.
- SUMA_AB:
  - sumandoA=opA[4*indice+:4], sumandoB=opB[4*indice+:4].
  - parcial<=suma (5 bits). Go SUMA_C.
- SUMA_C:
  - sumandoA=parcial[3:0], sumandoB={3'b000,acarreo}.
  - acum[4*indice+:4]<=suma[3:0].
  - acarreo<=parcial[4]|suma[4]. Both cannot be 1; the bench asserts this.
  - If indice==NIBBLES-1, go FIN; else indice<=indice+1 and go SUMA_AB.
- FIN:
  - resultado<={acarreo, acum}; listo<=1 for exactly this one cycle (registered output, high during the cycle after FIN entry edge). Go REPOSO.
- Latency: inicio accepted at edge 0. listo is high in cycle 2*NIBBLES+1 after that edge, and resultado is valid in the same cycle.
- ocupado is registered: 1 from the cycle after acceptance until the cycle listo is high, inclusive. It deasserts when the state returns to REPOSO.
- inicio while ocupado=1: ignored, with no queuing. Operand changes while busy have no effect.
- Back-to-back: inicio high in the cycle after listo (state REPOSO) is accepted immediately.
- Width rules: all arithmetic is unsigned, with no wrap. Carry out of the top nibble is kept in resultado[W]. Max result is 2^(W+1)-2.
- Adder path is purely combinational: sumandoA/B are a function of state, indice and registers only, with no dependence on suma (no loop).

Test Plan:
- NIBBLES=4, reset then A=0x1234, B=0x4321 -> listo in cycle 9, resultado=0x05555, ocupado high cycles 1-9.
- A=0xFFFF, B=0x0001 -> carry ripples via SUMA_C each nibble; resultado=0x10000; no cycle has parcial[4]&suma[4].
- A=0xFFFF, B=0xFFFF -> resultado=0x1FFFE; A=0x0000, B=0x0000 -> resultado=0x00000, listo still pulses once.
- Start A=0x00FF, B=0x0001, then pulse inicio with A=0x1111, B=0x1111 at cycle 3 -> ignored; resultado=0x00100. Re-issue inicio in the cycle after listo -> accepted, resultado=0x02222.
- Assert rst in cycle 4 of an operation -> ocupado/listo/resultado=0 immediately, with no listo afterwards. A new start after release completes correctly (0x8000+0x8000=0x10000).
- NIBBLES=1: A=0xF, B=0x1 -> listo in cycle 3, resultado=5'h10; NIBBLES=2: A=0x9F, B=0x61 -> resultado=9'h100.
